umips_ifetch: RTL
=================

UMIPS_IFETCH -- requirements
Module: umips_ifetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the cycles an outstanding fetch may wait for imem_ack before a bus error (used only with UMIPS_IFETCH_TIMEOUT_EN).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 pc_i  input  32  current PC from the upstream PC register.
REQ-005 pc_stall_o  output  1  stall to the PC register; 0 = PC may advance or load a branch target this cycle.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  32  read address, stable while imem_req=1.
REQ-008 imem_ack  input  1  single-cycle read acknowledge.
REQ-009 imem_rdata  input  32  read data, valid only when imem_ack=1.
REQ-010 stall_i  input  1  decode stall; outputs SHALL hold while 1.
REQ-011 flush_i  input  1  branch/jump redirect; discards in-flight and presented instruction.
REQ-012 valid_o  output  1  instr_o/pc_o carry a live instruction.
REQ-013 instr_o  output  32  fetched instruction to decode.
REQ-014 pc_o  output  32  address of instr_o.
REQ-015 ibus_err_o  output  1  fetch bus error flag accompanying instr_o.

Function
REQ-016 States SHALL be IDLE, REQ, HOLD, KILL.
REQ-017 IDLE: flush_i=0 -> latch pc_i into imem_addr, go REQ; flush_i=1 -> stay IDLE.
REQ-018 REQ: imem_req=1; no ack -> stay REQ; ack, flush_i=0, stall_i=0 -> instr_o<=imem_rdata, pc_o<=imem_addr, valid_o<=1, go IDLE.
REQ-019 REQ, ack, flush_i=0, stall_i=1 -> capture data/address into hold buffer, outputs unchanged, go HOLD.
REQ-020 HOLD: stall_i=0 -> transfer buffer to outputs with valid_o<=1, go IDLE; stall_i=1 -> stay HOLD.
REQ-021 REQ, flush_i=1: with ack -> discard data, go IDLE; without ack -> go KILL.
REQ-022 KILL: imem_req held 1, address unchanged; on ack discard data, go IDLE; flush_i ignored.
REQ-023 HOLD, flush_i=1 -> discard buffer, go IDLE.
REQ-024 pc_stall_o SHALL be 0 exactly in delivery cycles (REQ-018, REQ-020) or when flush_i=1; otherwise 1.
REQ-025 Any cycle with flush_i=1 SHALL set valid_o<=0 next edge regardless of stall_i (flush over stall).
REQ-026 stall_i=1, flush_i=0: valid_o, instr_o, pc_o, ibus_err_o SHALL hold.
REQ-027 stall_i=0, no delivery, no flush: valid_o<=0 (bubble); instr_o/pc_o may hold stale values.
REQ-028 Best-case throughput one instruction per two cycles (IDLE+REQ with same-cycle ack).
REQ-029 imem_req SHALL be 0 in IDLE and HOLD.

Reset
REQ-030 rst=0 SHALL force state IDLE, imem_req=0, imem_addr=0, valid_o=0, instr_o=0, pc_o=0, ibus_err_o=0, hold buffer cleared, timeout counter 0, pc_stall_o=1, asynchronously.
REQ-031 Reset mid-transaction SHALL drop imem_req immediately; a late ack after reset release while IDLE SHALL be ignored.

Configuration
REQ-032 Macro UMIPS_IFETCH_TIMEOUT_EN defined: counter clears on entering REQ/KILL, increments each cycle in REQ/KILL without ack.
REQ-033 Count reaching TIMEOUT_CYCLES in REQ: drop imem_req, deliver instr 0x00000000 with ibus_err_o=1 under REQ-018/019 stall rules; in KILL: drop imem_req, go IDLE.
REQ-034 ibus_err_o SHALL be 0 on every non-timeout delivery.
REQ-035 Macro undefined: no counter, ibus_err_o tied 0, REQ/KILL wait for ack indefinitely.

Verification
REQ-036 pc_i=0xBFC00000, ack one cycle after req, rdata=0x24080005, stall/flush 0 -> valid_o=1, instr_o=0x24080005, pc_o=0xBFC00000, one-cycle pc_stall_o=0.
REQ-037 Ack with stall_i=1 for 3 cycles -> outputs unchanged 3 cycles, then captured word presented, pc_stall_o=0 that cycle only.
REQ-038 flush_i pulsed 2 cycles before delayed ack -> imem_req held until ack, data discarded, valid_o=0, next req uses new pc_i.
REQ-039 flush_i and stall_i together in HOLD -> valid_o=0 next cycle, buffer dropped, state IDLE.
REQ-040 UMIPS_IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never -> after 16 REQ cycles imem_req=0, instr_o=0x00000000, ibus_err_o=1, valid_o=1.
REQ-041 rst asserted while imem_req=1 -> imem_req, valid_o 0 same cycle; post-release first req at current pc_i.

Source files
------------

// File: rtl/umips_ifetch.sv
// ============================================================================
// Module   : umips_ifetch
// Brief    : Single-outstanding instruction fetch stage with flush/stall
//            handling and an optional fetch-timeout bus error
//            (enabled by defining UMIPS_IFETCH_TIMEOUT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module umips_ifetch #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_stall_o,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        ibus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic        r_hold_err;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_err;
  logic        w_tmo;
  logic        w_fin;
  logic        w_deliver;
  logic        w_capture;
  logic [31:0] w_fin_instr;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic        w_out_err;

`ifdef UMIPS_IFETCH_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] r_tmo_cnt;
  logic               w_waiting;

  assign w_waiting = (r_state == S_REQ) || (r_state == S_KILL);
  // Fires in the TIMEOUT_CYCLES-th waiting cycle, so the error is presented
  // right after that many request cycles.
  assign w_tmo     = w_waiting && !imem_ack &&
                     (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmo_cnt <= '0;
    end else if (w_waiting && !imem_ack) begin
      r_tmo_cnt <= r_tmo_cnt + c_cnt_w'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_fin       = imem_ack || w_tmo;
  assign w_fin_instr = w_tmo ? 32'h0000_0000 : imem_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_deliver   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush_i) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (flush_i) begin
          w_state_nxt = w_fin ? S_IDLE : S_KILL;
        end else if (w_fin) begin
          if (stall_i) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else if (!stall_i) begin
          w_deliver   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_KILL: begin
        if (w_fin) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_out_instr = (r_state == S_HOLD) ? r_hold_instr : w_fin_instr;
  assign w_out_pc    = (r_state == S_HOLD) ? r_hold_pc    : r_addr;
  assign w_out_err   = (r_state == S_HOLD) ? r_hold_err   : w_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_hold_err   <= 1'b0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_pc         <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && !flush_i) r_addr <= pc_i;
      if (w_capture) begin
        r_hold_instr <= w_fin_instr;
        r_hold_pc    <= r_addr;
        r_hold_err   <= w_tmo;
      end
      // Flush beats stall; a stall freezes the presented instruction.
      if (flush_i)       r_valid <= 1'b0;
      else if (!stall_i) r_valid <= w_deliver;
      if (w_deliver) begin
        r_instr <= w_out_instr;
        r_pc    <= w_out_pc;
        r_err   <= w_out_err;
      end
    end
  end

  // Request is decoded from state so an asynchronous reset drops it at once.
  assign imem_req   = (r_state == S_REQ) || (r_state == S_KILL);
  assign imem_addr  = r_addr;
  assign pc_stall_o = !rst || !(w_deliver || flush_i);
  assign valid_o    = r_valid;
  assign instr_o    = r_instr;
  assign pc_o       = r_pc;
  assign ibus_err_o = r_err;

endmodule

`default_nettype wire
